// File: rtl/alarm_ring_controller_pkg.sv
//------------------------------------------------------------------------------
// Module   : alarm_pkg
// Brief    : Shared types and sizing helpers for the alarm ring controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } ring_state_t;

  localparam int SNOOZE_CNT_W = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // A counter must be at least one bit wide even when its terminal count is 1.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_ring_controller_edge_rise.sv
//------------------------------------------------------------------------------
// Module   : edge_rise
// Brief    : Registers a level and emits a one-cycle pulse on its rising edge.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module edge_rise #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_q;

  // History resets high so a level already asserted at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_rise = i_d & ~r_q;

endmodule

`default_nettype wire

// File: rtl/alarm_ring_controller.sv
//------------------------------------------------------------------------------
// Module   : alarm_ring_controller
// Brief    : Turns an alarm match edge into a timed beeping buzzer with snooze.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alarm_ring_controller
  import alarm_pkg::*;
#(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZE     = 3,
  parameter int TONE_HALF      = 500
) (
  input  logic                    GlobalClock,
  input  logic                    reset_n,
  input  logic                    tick_1hz,
  input  logic                    match,
  input  logic                    alarm_en,
  input  logic                    snooze_btn,
  input  logic                    stop_btn,
  output logic                    buzzer,
  output logic                    ringing,
  output logic                    snoozing,
  output logic [SNOOZE_CNT_W-1:0] snooze_cnt
);

  localparam int c_tick_w = cnt_width(max_int(RING_TIMEOUT_S, SNOOZE_S));
  localparam int c_tone_w = cnt_width(TONE_HALF);

  localparam logic [c_tick_w-1:0]     c_ring_last  = c_tick_w'(RING_TIMEOUT_S - 1);
  localparam logic [c_tick_w-1:0]     c_snz_last   = c_tick_w'(SNOOZE_S - 1);
  localparam logic [c_tone_w-1:0]     c_tone_last  = c_tone_w'(TONE_HALF - 1);
  localparam logic [SNOOZE_CNT_W-1:0] c_max_snooze = SNOOZE_CNT_W'(MAX_SNOOZE);

  logic w_match_rise, w_snooze_rise, w_stop_rise;

  ring_state_t             r_state,      w_state_nxt;
  logic [c_tick_w-1:0]     r_tick_cnt,   w_tick_cnt_nxt;
  logic [SNOOZE_CNT_W-1:0] r_snooze_cnt, w_snooze_cnt_nxt;
  logic                    r_beep_phase, w_beep_phase_nxt;
  logic [c_tone_w-1:0]     r_tone_cnt,   w_tone_cnt_nxt;
  logic                    r_tone,       w_tone_nxt;
  logic                    r_buzzer,     w_buzzer_nxt;

  edge_rise #(.RESET_VAL(1'b1)) u_match_edge (
    .clk(GlobalClock), .reset_n(reset_n), .i_d(match), .o_rise(w_match_rise)
  );

  edge_rise #(.RESET_VAL(1'b1)) u_snooze_edge (
    .clk(GlobalClock), .reset_n(reset_n), .i_d(snooze_btn), .o_rise(w_snooze_rise)
  );

  edge_rise #(.RESET_VAL(1'b1)) u_stop_edge (
    .clk(GlobalClock), .reset_n(reset_n), .i_d(stop_btn), .o_rise(w_stop_rise)
  );

  always_ff @(posedge GlobalClock) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_tick_cnt   <= '0;
      r_snooze_cnt <= '0;
      r_beep_phase <= 1'b0;
      r_tone_cnt   <= '0;
      r_tone       <= 1'b0;
      r_buzzer     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tick_cnt   <= w_tick_cnt_nxt;
      r_snooze_cnt <= w_snooze_cnt_nxt;
      r_beep_phase <= w_beep_phase_nxt;
      r_tone_cnt   <= w_tone_cnt_nxt;
      r_tone       <= w_tone_nxt;
      r_buzzer     <= w_buzzer_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_tick_cnt_nxt   = r_tick_cnt;
    w_snooze_cnt_nxt = r_snooze_cnt;
    w_beep_phase_nxt = r_beep_phase;

    unique case (r_state)
      ST_IDLE: begin
        if (w_match_rise && alarm_en) begin
          w_state_nxt      = ST_RINGING;
          w_tick_cnt_nxt   = '0;
          w_snooze_cnt_nxt = '0;
          w_beep_phase_nxt = 1'b1;
        end
      end

      ST_RINGING: begin
        // Stop beats snooze beats timeout; a snooze at the limit falls through.
        if (!alarm_en || w_stop_rise) begin
          w_state_nxt      = ST_IDLE;
          w_tick_cnt_nxt   = '0;
          w_snooze_cnt_nxt = '0;
        end else if (w_snooze_rise && (r_snooze_cnt < c_max_snooze)) begin
          w_state_nxt      = ST_SNOOZE;
          w_tick_cnt_nxt   = '0;
          w_snooze_cnt_nxt = r_snooze_cnt + 1'b1;
        end else if (tick_1hz) begin
          if (r_tick_cnt == c_ring_last) begin
            w_state_nxt      = ST_IDLE;
            w_tick_cnt_nxt   = '0;
            w_snooze_cnt_nxt = '0;
          end else begin
            w_tick_cnt_nxt   = r_tick_cnt + 1'b1;
            w_beep_phase_nxt = ~r_beep_phase;
          end
        end
      end

      ST_SNOOZE: begin
        if (!alarm_en || w_stop_rise) begin
          w_state_nxt      = ST_IDLE;
          w_tick_cnt_nxt   = '0;
          w_snooze_cnt_nxt = '0;
        end else if (tick_1hz) begin
          if (r_tick_cnt == c_snz_last) begin
            w_state_nxt      = ST_RINGING;
            w_tick_cnt_nxt   = '0;
            w_beep_phase_nxt = 1'b1;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt      = ST_IDLE;
        w_tick_cnt_nxt   = '0;
        w_snooze_cnt_nxt = '0;
      end
    endcase
  end

  // The tone restarts from its low half on every entry into ringing.
  always_comb begin
    w_tone_cnt_nxt = '0;
    w_tone_nxt     = 1'b0;
    if ((r_state == ST_RINGING) && (w_state_nxt == ST_RINGING)) begin
      if (r_tone_cnt == c_tone_last) begin
        w_tone_cnt_nxt = '0;
        w_tone_nxt     = ~r_tone;
      end else begin
        w_tone_cnt_nxt = r_tone_cnt + 1'b1;
        w_tone_nxt     = r_tone;
      end
    end
  end

  // Built from next-state values so the buzzer lines up with the ringing flag.
  assign w_buzzer_nxt = (w_state_nxt == ST_RINGING) & w_beep_phase_nxt & w_tone_nxt;

  assign buzzer     = r_buzzer;
  assign ringing    = (r_state == ST_RINGING);
  assign snoozing   = (r_state == ST_SNOOZE);
  assign snooze_cnt = r_snooze_cnt;

endmodule

`default_nettype wire

// File: doc/alarm_ring_controller.md
Name: alarm_ring_controller

Overview:
- Response side of the alarm-match path. The time-vs-alarm comparator (a wide AND of the digit-equality bits) raises `match`.
- This block turns a rising edge of `match` into a timed, beeping buzzer output, with snooze, stop and auto-timeout.
- It sits between the compare logic and the buzzer pin, and is clocked by the single system clock. Second timing comes from the shared 1 Hz enable pulse.

Parameters:
- RING_TIMEOUT_S, 60, ticks (seconds) of ringing before auto-off.
- SNOOZE_S, 300, ticks spent in snooze before re-ringing.
- MAX_SNOOZE, 3, snoozes allowed per alarm event; range 1..7.
- TONE_HALF, 500, clock cycles per half-period of the buzzer tone; must be ≥1.

Ports:
- GlobalClock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- tick_1hz  in  1  one-cycle enable pulse, once per second.
- match  in  1  level; high while current time equals alarm time.
- alarm_en  in  1  level; alarm armed switch.
- snooze_btn  in  1  debounced, synchronous level.
- stop_btn  in  1  debounced, synchronous level.
- buzzer  out  1  gated tone to the piezo.
- ringing  out  1  high in RINGING.
- snoozing  out  1  high in SNOOZE.
- snooze_cnt  out  3  snoozes used in the current event.

Behaviour:
- Reset, sampled when reset_n=0 at a clock edge:
  - state=IDLE.
  - Outputs buzzer, ringing, snoozing = 0; snooze_cnt = 0.
  - Tick, tone and beep counters cleared.
  - Edge-detector history regs for match, snooze_btn and stop_btn reset to 1. A signal already high at reset release therefore produces no edge.
  - Reset mid-ring or mid-snooze aborts immediately.
- Edge detection: `x_rise = x & ~x_q`, with x_q registered each cycle. Only rises act; a held button acts once.
- States: IDLE, RINGING, SNOOZE. All transitions are registered, so outputs change on the edge after the triggering input is sampled (1-cycle latency).
- IDLE -> RINGING:
  - Condition: match_rise & alarm_en.
  - Actions: clear tick_cnt, snooze_cnt=0, beep_phase=1.
  - match staying high after stop does not re-ring; only a new rising edge does.
- RINGING, priority order (highest first):
  - 1. alarm_en=0 or stop_rise -> IDLE.
  - 2. snooze_rise with snooze_cnt<MAX_SNOOZE -> SNOOZE; snooze_cnt+1; clear tick_cnt.
  - 3. snooze_rise with snooze_cnt==MAX_SNOOZE is ignored; stay RINGING.
  - 4. tick_1hz with tick_cnt==RING_TIMEOUT_S-1 -> IDLE (exactly RING_TIMEOUT_S ticks rung).
  - 5. otherwise, tick_1hz increments tick_cnt and toggles beep_phase.
- SNOOZE, priority order (highest first):
  - 1. alarm_en=0 or stop_rise -> IDLE.
  - 2. tick_1hz with tick_cnt==SNOOZE_S-1 -> RINGING; clear tick_cnt; beep_phase=1.
  - 3. snooze_rise and match_rise are ignored.
- Simultaneous events: stop beats snooze beats timeout. A snooze and a timeout tick on the same cycle takes the snooze.
- Tone generator:
  - tone_cnt counts 0..TONE_HALF-1 continuously while ringing; at wrap, tone toggles.
  - tone_cnt and tone are held at 0 outside RINGING.
- buzzer = registered (ringing & beep_phase & tone). Beeps alternate 1 s on / 1 s off, starting on.
- Entering IDLE clears snooze_cnt to 0 on the same edge.
- Width rules:
  - tick_cnt width = clog2(max(RING_TIMEOUT_S, SNOOZE_S)).
  - tone_cnt width = clog2(TONE_HALF).
  - Counters never exceed terminal values; no wrap beyond the compare.

Decomposition:
- Package alarm_pkg:
  - state encoding (IDLE=0, RINGING=1, SNOOZE=2; 2-bit);
  - SNOOZE_CNT_W=3;
  - the width function used for counter sizing.
- One sub-module, edge_rise, with parameter RESET_VAL (default 1). It registers its input and outputs the one-cycle rise. It is instantiated three times: match, snooze_btn, stop_btn.

Test Plan (RING_TIMEOUT_S=4, SNOOZE_S=3, MAX_SNOOZE=2, TONE_HALF=2):
- Basic ring and timeout: alarm_en=1; reset released with match=0; raise match -> ringing=1 next cycle; buzzer toggles every 2 cycles only in on-seconds; after 4 ticks ringing=0 and buzzer=0; match held high afterwards causes no re-ring.
- Snooze cycle: ring, press snooze -> snoozing=1, snooze_cnt=1, buzzer=0; after 3 ticks ringing=1, tick_cnt=0; snooze again -> snooze_cnt=2; third snooze press while ringing is ignored (ringing stays 1).
- Stop wins: snooze_btn and stop_btn rise on the same cycle while ringing -> IDLE, snooze_cnt=0; stop held high for 10 cycles, then a new match edge -> rings normally.
- Reset with match high: match=1 during reset and after release -> stays IDLE. Reset asserted mid-SNOOZE for 1 cycle -> all outputs 0 next edge.
- Disarm: alarm_en dropped during SNOOZE -> IDLE. match rise while alarm_en=0 -> no ring.
- Boundary: snooze_rise on the same cycle as the 4th (timeout) tick -> SNOOZE entered, not IDLE.
